// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Holds the FSM encoding and the constant branch-target table.
package cpu_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 4;
  localparam int LUT_N     = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Absolute branch targets; undefined entries are zero.
  localparam logic [PC_W-1:0] BR_LUT [LUT_N] = '{
    10'd100, 10'd200, 10'd40,  10'd512,
    10'd1023, 10'd7,  10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0
  };

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup.
// Pure combinational read of the package table.
module branch_lut #(
  parameter int PC_W      = cpu_pkg::PC_W,
  parameter int LUT_IDX_W = cpu_pkg::LUT_IDX_W
) (
  input  logic [LUT_IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]      o_target
);

  import cpu_pkg::*;

  // Table read, resized to the local PC width.
  always_comb begin
    o_target = PC_W'(BR_LUT[i_idx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer.
// IDLE/RUN/DONE FSM with branch table and run-cycle counter.
module fetch_unit #(
  parameter int PC_W      = cpu_pkg::PC_W,
  parameter int LUT_IDX_W = cpu_pkg::LUT_IDX_W,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Branch,
  input  logic [LUT_IDX_W-1:0] TargetIdx,
  input  logic                 Halt,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 InstrValid,
  output logic                 Done,
  output logic [CNT_W-1:0]     CycleCount
);

  import cpu_pkg::*;

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PC_W-1:0]  w_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .i_idx    (TargetIdx),
    .o_target (w_target)
  );

  // State, PC and counter registers; reset abandons any program.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, next-PC and saturating count selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (r_cnt != '1)
          w_cnt_nxt = r_cnt + 1'b1;
        if (Halt)
          w_state_nxt = DONE;
        else if (Branch)
          w_pc_nxt = w_target;
        else
          w_pc_nxt = r_pc + 1'b1;
      end
      IDLE, DONE: begin
        if (Start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    ProgCtr    = r_pc;
    CycleCount = r_cnt;
    InstrValid = (r_state == RUN);
    Done       = (r_state == DONE);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the ALU.
- Produces the instruction address each cycle and marks fetched instructions valid.
- Consumes the ALU's Branch output and the decoder's halt indication to choose the next address.
- Branch targets are absolute addresses taken from a small constant target lookup table, indexed by a field of the current instruction.

Parameters:
- PC_W, 10, width of the program counter and instruction-memory address.
- LUT_IDX_W, 4, width of the branch-target index; the table has 2**LUT_IDX_W entries.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; begins program execution from address 0.
- Branch  input  1  from ALU; current instruction resolves as taken.
- TargetIdx  input  LUT_IDX_W  branch-target table index from the current instruction.
- Halt  input  1  from decoder; current instruction is the program's final instruction.
- ProgCtr  output  PC_W  address presented to instruction memory (combinational read).
- InstrValid  output  1  high while the instruction at ProgCtr is to be executed.
- Done  output  1  program finished; held until next Start.
- CycleCount  output  CNT_W  number of RUN cycles in current/last program.

Behaviour:
- States: IDLE, RUN, DONE (encoding in package).
- Reset (synchronous, Reset=1 at edge):
  - state=IDLE, ProgCtr=0, Done=0, CycleCount=0, InstrValid=0.
  - Reset wins over every other input, including mid-RUN; the in-flight program is abandoned.
- IDLE:
  - InstrValid=0.
  - Start=1 -> RUN, ProgCtr=0, CycleCount=0.
  - Branch and Halt are ignored.
- RUN:
  - InstrValid=1 (combinational from state).
  - Each edge: CycleCount increments, saturating at 2**CNT_W-1 (no wrap).
  - Next ProgCtr, in priority order:
    - Halt=1 -> hold ProgCtr, state -> DONE.
    - Branch=1 -> ProgCtr = LUT[TargetIdx].
    - Otherwise -> ProgCtr+1, wrapping from 2**PC_W-1 to 0.
  - Start during RUN is ignored.
- DONE:
  - Done=1, InstrValid=0; ProgCtr and CycleCount are held.
  - Start=1 -> RUN, ProgCtr=0, CycleCount=0, Done=0 on that edge.
- Latency:
  - Branch, Halt and TargetIdx are sampled in the same cycle as the instruction they belong to.
  - The new ProgCtr is visible one cycle later; there are no delay slots.
  - The cycle with Halt=1 is counted in CycleCount.
- Target table:
  - Width PC_W; entry values are fixed constants.
  - Entries not explicitly defined are 0.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum fetch_state_t {IDLE, RUN, DONE};
  - PC_W and LUT_IDX_W constants;
  - the branch-target constant array.
- One sub-module, branch_lut: combinational, TargetIdx -> PC_W-bit target, read from the package array.
- fetch_unit instantiates branch_lut and holds the FSM, PC and counter.

Test Plan:
- Reset then Start pulse, no Branch/Halt for 5 cycles -> ProgCtr 0,1,2,3,4,5; InstrValid=1 from the cycle after Start; CycleCount=5.
- In RUN at ProgCtr=3, Branch=1, TargetIdx=2, LUT[2]=40 -> next ProgCtr=40, then 41.
- Halt=1 and Branch=1 at ProgCtr=7 -> next state DONE, ProgCtr=7, Done=1, InstrValid=0; Start one cycle later -> ProgCtr=0, Done=0, CycleCount=0.
- Preload ProgCtr=1023 (PC_W=10) with no branch -> next ProgCtr=0; with CNT_W=4, run 20 cycles -> CycleCount stays 15.
- Reset asserted mid-RUN at ProgCtr=12 with Branch=1 -> next cycle IDLE, ProgCtr=0, CycleCount=0, Done=0.
- Branch/Halt pulsed in IDLE and Start pulsed in RUN -> no state or ProgCtr change attributable to them.
